// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO controller driving an external dual-port RAM (port A writes, port B reads).
// A 2-entry output buffer hides the RAM read latency and gives a first-word-fall-through output.
module dpram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] RAM_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   ram_used;
    logic                  inflight;
    logic [1:0]            ob_cnt;
    logic [DATA_WIDTH-1:0] ob_head;
    logic [DATA_WIDTH-1:0] ob_tail;
    logic                  ram_full;
    logic                  push;
    logic                  pop;
    logic                  rd_en;
    logic [2:0]            ob_occ;

    // Wrap bit makes full (difference == DEPTH) distinct from empty (difference == 0).
    assign ram_used = wr_ptr - rd_ptr;
    assign ram_full = (ram_used == RAM_FULL);

    assign s_ready = rst_n & ~ram_full;
    assign push    = s_valid & s_ready;
    assign m_valid = (ob_cnt != 2'd0);
    assign m_data  = ob_head;
    assign pop     = m_valid & m_ready;

    // Occupancy the buffer will have once this cycle's pop and pending capture settle.
    assign ob_occ = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_en  = (ram_used != '0) && (ob_occ < 3'd2);

    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_din_a  = s_data;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rd_ptr[ADDR_WIDTH-1:0];
    assign ram_din_b  = '0;

    assign level = {1'b0, ram_used}
                 + {{(ADDR_WIDTH+1){1'b0}}, inflight}
                 + {{ADDR_WIDTH{1'b0}}, ob_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            ob_cnt   <= 2'd0;
            ob_head  <= '0;
            ob_tail  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_ONE;
            inflight <= rd_en;

            // Capture of the RAM word (inflight) and a consumer pop may coincide.
            case ({pop, inflight})
                2'b11: begin
                    if (ob_cnt == 2'd1) begin
                        ob_head <= ram_dout_b;
                    end else begin
                        ob_head <= ob_tail;
                        ob_tail <= ram_dout_b;
                    end
                end
                2'b10: begin
                    ob_head <= ob_tail;
                    ob_cnt  <= ob_cnt - 2'd1;
                end
                2'b01: begin
                    if (ob_cnt == 2'd0)
                        ob_head <= ram_dout_b;
                    else
                        ob_tail <= ram_dout_b;
                    ob_cnt <= ob_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural dual-port RAM; queue scoreboard of accepted words.
module tb_dpram_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW+1:0] level;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_we_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_din_b;
    logic [DW-1:0] ram_dout_b;

    logic [DW-1:0] mem [1<<AW];

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] q [$];
    bit            push_s;
    bit            pop_s;

    dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_din_b  (ram_din_b),
        .ram_dout_b (ram_dout_b)
    );

    always #5 clk = ~clk;

    // Registered-read RAM, port B read-only.
    always @(posedge clk) begin
        if (ram_we_a)
            mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: decide handshakes on the falling edge, score them, then look after the rising edge.
    task automatic step();
        logic [DW-1:0] exp_d;
        @(negedge clk);
        push_s = s_valid && s_ready;
        pop_s  = m_valid && m_ready;
        if (pop_s) begin
            if (q.size() == 0) begin
                check("pop_unexpected", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                exp_d = q.pop_front();
                check("m_data", 32'(m_data), 32'(exp_d));
            end
        end
        if (ram_we_a && dut.rd_en)
            check("addr_collision", 32'(ram_addr_a != ram_addr_b), 32'd1);
        if (push_s)
            q.push_back(s_data);
        @(posedge clk);
        #1;
        if (rst_n)
            check("level", 32'(level), 32'(q.size()));
        else
            check("level_rst", 32'(level), 32'd0);
    endtask

    task automatic drain(input string tag);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 40 && q.size() != 0; k++)
            step();
        check(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int pushed;
        int steps;
        int npop;

        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h55;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready",  32'(s_ready),  32'd0);
        check("rst_m_valid",  32'(m_valid),  32'd0);
        check("rst_m_data",   32'(m_data),   32'd0);
        check("rst_level",    32'(level),    32'd0);
        check("rst_ram_we_a", 32'(ram_we_a), 32'd0);
        check("ram_we_b",     32'(ram_we_b), 32'd0);
        check("ram_din_b",    32'(ram_din_b), 32'd0);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        #1;
        check("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Single word: visible two edges after acceptance.
        s_valid = 1'b1;
        s_data  = 8'hA5;
        step();
        check("single_push", 32'(push_s), 32'd1);
        s_valid = 1'b0;
        check("single_mv_e0", 32'(m_valid), 32'd0);
        step();
        check("single_mv_e1", 32'(m_valid), 32'd0);
        step();
        check("single_mv_e2",   32'(m_valid), 32'd1);
        check("single_data_e2", 32'(m_data),  32'hA5);
        m_ready = 1'b1;
        step();
        check("single_pop",     32'(pop_s),   32'd1);
        check("single_mv_done", 32'(m_valid), 32'd0);
        check("single_level",   32'(level),   32'd0);

        // Fill to capacity with the consumer stalled.
        m_ready = 1'b0;
        acc = 0;
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            step();
            if (push_s) acc++;
        end
        check("fill_accepted", 32'(acc),     32'd6);
        check("fill_s_ready",  32'(s_ready), 32'd0);
        check("fill_level",    32'(level),   32'd6);
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        check("fill_first_pop",  32'(pop_s),   32'd1);
        check("fill_ready_back", 32'(s_ready), 32'd1);
        drain("fill_drain");

        // Streaming through pointer wrap at one word per cycle.
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h10 + i);
            m_ready = 1'b1;
            step();
            check("stream_push", 32'(push_s), 32'd1);
            if (i >= 3)
                check("stream_pop", 32'(pop_s), 32'd1);
        end
        drain("stream_drain");

        // Random valid/ready at 50%.
        pushed = 0;
        steps  = 0;
        while (pushed < 1000 && steps < 20000) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            step();
            if (push_s) pushed++;
            steps++;
        end
        check("rand_pushed", 32'(pushed), 32'd1000);
        drain("rand_drain");

        // Reset while a RAM read is in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'hB0 + i);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        check("midrst_pop", 32'(pop_s), 32'd1);
        rst_n   = 1'b0;
        m_ready = 1'b0;
        q.delete();
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_data",  32'(m_data),  32'd0);
        check("midrst_level",   32'(level),   32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        step();
        rst_n   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h3C;
        step();
        check("midrst_push", 32'(push_s), 32'd1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        npop = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (pop_s) npop++;
        end
        check("midrst_npop",  32'(npop),    32'd1);
        check("midrst_empty", 32'(m_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
